// File: rtl/stream_tagged_fifo.sv
// rtl/stream_tagged_fifo.sv - flushable stream FIFO storing {data, source idx} with per-source occupancy
module stream_tagged_fifo #(
    parameter type DATA_T = logic,
    parameter int  N_INP  = -1,
    parameter int  DEPTH  = 4,
    parameter int  IDX_W  = (N_INP > 1) ? $clog2(N_INP) : 1,
    parameter int  CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    input  DATA_T                                         inp_data_i,
    input  logic [IDX_W-1:0]                              inp_idx_i,
    input  logic                                          inp_valid_i,
    output logic                                          inp_ready_o,
    output DATA_T                                         oup_data_o,
    output logic [IDX_W-1:0]                              oup_idx_o,
    output logic                                          oup_valid_o,
    input  logic                                          oup_ready_i,
    output logic [CNT_W-1:0]                              usage_o,
    output logic [((N_INP < 1) ? 1 : N_INP)*CNT_W-1:0]    src_cnt_o
);

    // Guard against the unset default so array ranges stay well formed.
    localparam int N_SAFE = (N_INP < 1) ? 1 : N_INP;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    DATA_T             r_data    [DEPTH];
    logic [IDX_W-1:0]  r_idx     [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_usage;
    logic [CNT_W-1:0]  r_src_cnt [N_SAFE];

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [IDX_W-1:0]  w_head_idx;
    logic [N_SAFE-1:0] w_inc;
    logic [N_SAFE-1:0] w_dec;

    assign w_full      = (r_usage == CNT_W'(DEPTH));
    assign w_empty     = (r_usage == '0);
    assign inp_ready_o = !w_full && !flush_i;
    assign oup_valid_o = !w_empty;
    assign w_push      = inp_valid_i && inp_ready_o;
    assign w_pop       = oup_valid_o && oup_ready_i;
    assign w_head_idx  = r_idx[r_rd_ptr];
    assign oup_data_o  = r_data[r_rd_ptr];
    assign oup_idx_o   = w_head_idx;
    assign usage_o     = r_usage;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < N_SAFE; i++) begin
            w_inc[i] = w_push && (inp_idx_i == IDX_W'(i));
            w_dec[i] = w_pop && (w_head_idx == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < N_SAFE; g++) begin : g_src_out
        assign src_cnt_o[g*CNT_W +: CNT_W] = r_src_cnt[g];
    end

    // Storage is deliberately left out of reset; valid gates the head view.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= inp_data_i;
            r_idx[r_wr_ptr]  <= inp_idx_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_usage  <= '0;
            for (int i = 0; i < N_SAFE; i++) begin
                r_src_cnt[i] <= '0;
            end
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_usage  <= '0;
            for (int i = 0; i < N_SAFE; i++) begin
                r_src_cnt[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_usage <= r_usage + CNT_W'(1);
                2'b01:   r_usage <= r_usage - CNT_W'(1);
                default: r_usage <= r_usage;
            endcase
            for (int i = 0; i < N_SAFE; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_src_cnt[i] <= r_src_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_src_cnt[i] <= r_src_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    assert property (@(posedge clk_i)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) && (N_INP >= 1));

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        inp_valid_i |-> (int'(inp_idx_i) < N_INP));

    // Flush may legitimately retract a stalled beat, so it is excluded here.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (inp_valid_i && !inp_ready_o && !flush_i)
        |=> ($stable(inp_data_i) && $stable(inp_idx_i)));

    for (genvar g = 0; g < N_SAFE; g++) begin : g_cnt_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(w_dec[g] && !w_inc[g] && (r_src_cnt[g] == '0)));
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(w_inc[g] && !w_dec[g] && (r_src_cnt[g] == CNT_W'(DEPTH))));
    end

endmodule

// File: tb/tb_stream_tagged_fifo.sv
// tb/tb_stream_tagged_fifo.sv - randomized bench for stream_tagged_fifo against a queue model
module tb_stream_tagged_fifo;

    localparam int N_INP = 3;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int IDX_W = 2;

    logic                   clk_i       = 1'b0;
    logic                   rst_ni      = 1'b0;
    logic                   flush_i     = 1'b0;
    logic [7:0]             inp_data_i  = '0;
    logic [IDX_W-1:0]       inp_idx_i   = '0;
    logic                   inp_valid_i = 1'b0;
    logic                   inp_ready_o;
    logic [7:0]             oup_data_o;
    logic [IDX_W-1:0]       oup_idx_o;
    logic                   oup_valid_o;
    logic                   oup_ready_i = 1'b0;
    logic [CNT_W-1:0]       usage_o;
    logic [N_INP*CNT_W-1:0] src_cnt_o;

    stream_tagged_fifo #(
        .DATA_T (logic [7:0]),
        .N_INP  (N_INP),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .inp_data_i  (inp_data_i),
        .inp_idx_i   (inp_idx_i),
        .inp_valid_i (inp_valid_i),
        .inp_ready_o (inp_ready_o),
        .oup_data_o  (oup_data_o),
        .oup_idx_o   (oup_idx_o),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .usage_o     (usage_o),
        .src_cnt_o   (src_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         last_accepted = 1'b0;
    logic [7:0] m_data [$];
    logic [1:0] m_idx  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_src(input int s);
        int c = 0;
        foreach (m_idx[k]) begin
            if (int'(m_idx[k]) == s) c++;
        end
        return c;
    endfunction

    task automatic check_outputs();
        check("valid", 32'(oup_valid_o), 32'(m_data.size() != 0));
        check("ready", 32'(inp_ready_o), 32'((m_data.size() < DEPTH) && !flush_i));
        check("usage", 32'(usage_o), 32'(m_data.size()));
        for (int s = 0; s < N_INP; s++) begin
            check($sformatf("src%0d", s), 32'(src_cnt_o[s*CNT_W +: CNT_W]), 32'(model_src(s)));
        end
        if (m_data.size() != 0) begin
            check("head_data", 32'(oup_data_o), 32'(m_data[0]));
            check("head_idx", 32'(oup_idx_o), 32'(m_idx[0]));
        end
    endtask

    // Inputs are set one time unit after an edge; outputs are checked mid-cycle.
    task automatic tick();
        bit do_push;
        bit do_pop;
        #1;
        check_outputs();
        do_push = inp_valid_i && (m_data.size() < DEPTH) && !flush_i;
        do_pop  = (m_data.size() != 0) && oup_ready_i;
        @(posedge clk_i);
        if (flush_i) begin
            m_data.delete();
            m_idx.delete();
        end else begin
            if (do_pop) begin
                void'(m_data.pop_front());
                void'(m_idx.pop_front());
            end
            if (do_push) begin
                m_data.push_back(inp_data_i);
                m_idx.push_back(inp_idx_i);
            end
        end
        last_accepted = do_push;
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] idx, input logic rdy);
        inp_valid_i = 1'b1;
        inp_data_i  = d;
        inp_idx_i   = idx;
        oup_ready_i = rdy;
        tick();
        inp_valid_i = 1'b0;
    endtask

    task automatic drain();
        inp_valid_i = 1'b0;
        oup_ready_i = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        oup_ready_i = 1'b0;
    endtask

    initial begin
        int got;
        int guard;

        #2;
        check_outputs();
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic order
        push(8'h0A, 2'd0, 1'b0);
        push(8'h0B, 2'd2, 1'b0);
        push(8'h0C, 2'd2, 1'b0);
        #1;
        check("basic_usage", 32'(usage_o), 32'd3);
        check("basic_src2", 32'(src_cnt_o[2*CNT_W +: CNT_W]), 32'd2);
        drain();

        // Full, held fifth push, then wrap with random consumer
        for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i), 2'(i % N_INP), 1'b0);
        inp_valid_i = 1'b1;
        inp_data_i  = 8'h55;
        inp_idx_i   = 2'd1;
        tick();
        tick();
        oup_ready_i = 1'b1;
        tick();
        check("full_refused", 32'(last_accepted), 32'd0);
        tick();
        check("held_accepted", 32'(last_accepted), 32'd1);
        got = 0;
        guard = 0;
        inp_data_i = 8'h60;
        inp_idx_i  = 2'(0);
        while (got < 12 && guard < 200) begin
            oup_ready_i = 1'($urandom_range(0, 1));
            tick();
            guard++;
            if (last_accepted) begin
                got++;
                inp_data_i = 8'h60 + 8'(got);
                inp_idx_i  = 2'($urandom_range(0, N_INP - 1));
            end
        end
        check("wrap_beats", 32'(got), 32'd12);
        drain();

        // Simultaneous push and pop at usage 2
        push(8'h31, 2'd1, 1'b0);
        push(8'h32, 2'd2, 1'b0);
        push(8'h33, 2'd1, 1'b1);
        check("same_idx_usage", 32'(usage_o), 32'd2);
        check("same_idx_src1", 32'(src_cnt_o[1*CNT_W +: CNT_W]), 32'd1);
        push(8'h34, 2'd0, 1'b1);
        check("diff_idx_src0", 32'(src_cnt_o[0*CNT_W +: CNT_W]), 32'd1);
        check("diff_idx_src2", 32'(src_cnt_o[2*CNT_W +: CNT_W]), 32'd0);
        drain();

        // Flush with 3 entries while the consumer is ready
        push(8'h41, 2'd0, 1'b0);
        push(8'h42, 2'd1, 1'b0);
        push(8'h43, 2'd2, 1'b0);
        oup_ready_i = 1'b1;
        flush_i     = 1'b1;
        tick();
        flush_i     = 1'b0;
        oup_ready_i = 1'b0;
        tick();

        // Asynchronous reset between edges
        push(8'h51, 2'd0, 1'b0);
        push(8'h52, 2'd2, 1'b0);
        #1 rst_ni = 1'b0;
        #1;
        check("rst_valid", 32'(oup_valid_o), 32'd0);
        check("rst_usage", 32'(usage_o), 32'd0);
        check("rst_src", 32'(src_cnt_o), 32'd0);
        check("rst_ready", 32'(inp_ready_o), 32'd1);
        m_data.delete();
        m_idx.delete();
        rst_ni = 1'b1;
        tick();

        // Back-to-back streaming
        inp_valid_i = 1'b1;
        oup_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            inp_data_i = 8'h80 + 8'(i);
            inp_idx_i  = 2'($urandom_range(0, N_INP - 1));
            tick();
            check("stream_accept", 32'(last_accepted), 32'd1);
        end
        drain();

        // Random traffic with occasional flush
        inp_valid_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (last_accepted || !inp_valid_i) begin
                inp_valid_i = ($urandom_range(0, 3) != 0);
                inp_data_i  = 8'($urandom);
                inp_idx_i   = 2'($urandom_range(0, N_INP - 1));
            end
            oup_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush_i = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
